gray_position_tracker: RTL and testbench

- Sequencing controller around the Gray-to-binary conversion datapath for a WIDTH-bit Gray-coded position source, such as an absolute encoder or a cross-domain pointer.
- Synchronizes and de-glitches the asynchronous Gray input, then converts accepted codes to binary.
- Classifies each transition as step up, step down or illegal jump, and maintains a signed-wrap position accumulator plus error bookkeeping.
- Sits between the pad-level Gray bus and the downstream position/control logic.

---
 rtl/gray_position_tracker.sv | 164 ++++++++++++++++
 tb/tb_gray_position_tracker.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_position_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_position_tracker                                                    |
// | Synchronizes, de-glitches and decodes a Gray position bus; tracks steps. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gray_position_tracker #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 3,
    parameter int POS_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clear,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 valid,
    output logic                 step_up,
    output logic                 step_dn,
    output logic                 err,
    output logic                 err_flag,
    output logic [7:0]           err_count,
    output logic [POS_WIDTH-1:0] pos
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0]     sync1_q, gs_q;
    logic [WIDTH-1:0]     cand_q, cand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic                 valid_q, valid_d;
    logic                 step_up_q, step_up_d;
    logic                 step_dn_q, step_dn_d;
    logic                 err_q, err_d;
    logic                 err_flag_q, err_flag_d;
    logic [7:0]           err_count_q, err_count_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;

    logic [WIDTH-1:0]     w_bn;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_stable;

    always_comb begin
        w_bn     = gray_to_bin(cand_q);
        w_diff   = w_bn - bin_q;
        w_stable = (gs_q == cand_q) && (cnt_q == C_CNT_MAX);

        cand_d      = cand_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        bin_d       = bin_q;
        valid_d     = valid_q;
        step_up_d   = 1'b0;
        step_dn_d   = 1'b0;
        err_d       = 1'b0;
        err_flag_d  = err_flag_q;
        err_count_d = err_count_q;
        pos_d       = pos_q;

        // Any change restarts the stability count; the count parks at its max.
        if (gs_q != cand_q) begin
            cand_d = gs_q;
            cnt_d  = '0;
        end else if (cnt_q < C_CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_INIT: begin
                if (w_stable) begin
                    bin_d   = w_bn;
                    valid_d = 1'b1;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                // Gray decoding is bijective, so comparing binaries is enough.
                if (w_stable && (w_bn != bin_q)) begin
                    bin_d = w_bn;
                    if (w_diff == WIDTH'(1)) begin
                        step_up_d = 1'b1;
                        pos_d     = pos_q + POS_WIDTH'(1);
                    end else if (w_diff == {WIDTH{1'b1}}) begin
                        step_dn_d = 1'b1;
                        pos_d     = pos_q - POS_WIDTH'(1);
                    end else begin
                        err_d      = 1'b1;
                        err_flag_d = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (clear) begin
            pos_d       = '0;
            err_flag_d  = 1'b0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            gs_q        <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            state_q     <= ST_INIT;
            bin_q       <= '0;
            valid_q     <= 1'b0;
            step_up_q   <= 1'b0;
            step_dn_q   <= 1'b0;
            err_q       <= 1'b0;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
            pos_q       <= '0;
        end else begin
            sync1_q     <= gray_in;
            gs_q        <= sync1_q;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            bin_q       <= bin_d;
            valid_q     <= valid_d;
            step_up_q   <= step_up_d;
            step_dn_q   <= step_dn_d;
            err_q       <= err_d;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
            pos_q       <= pos_d;
        end
    end

    assign bin_out   = bin_q;
    assign valid     = valid_q;
    assign step_up   = step_up_q;
    assign step_dn   = step_dn_q;
    assign err       = err_q;
    assign err_flag  = err_flag_q;
    assign err_count = err_count_q;
    assign pos       = pos_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_position_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gray_position_tracker                                                 |
// | Self-checking bench with a behavioural step/error reference model.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_gray_position_tracker;

    localparam int W = 4;
    localparam int S = 3;
    localparam int P = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] gray_in = '0;
    logic         clear = 1'b0;
    logic [W-1:0] bin_out;
    logic         valid, step_up, step_dn, err, err_flag;
    logic [7:0]   err_count;
    logic [P-1:0] pos;

    int total = 0;
    int bad   = 0;

    gray_position_tracker #(.WIDTH(W), .STABLE_CYCLES(S), .POS_WIDTH(P)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clear(clear),
        .bin_out(bin_out), .valid(valid), .step_up(step_up), .step_dn(step_dn),
        .err(err), .err_flag(err_flag), .err_count(err_count), .pos(pos)
    );

    always #5 clk = ~clk;

    // Pulse-cycle counters; a two-cycle pulse counts twice.
    int n_up = 0, n_dn = 0, n_err = 0;
    always @(negedge clk) begin
        if (step_up) n_up++;
        if (step_dn) n_dn++;
        if (err)     n_err++;
    end

    // Reference model state
    bit           m_valid;
    logic [W-1:0] m_bin;
    logic [P-1:0] m_pos;
    bit           m_flag;
    int           m_cnt;
    int           e_up, e_dn, e_err;

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b = '0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(input logic [W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_bin = '0; m_pos = '0; m_flag = 0; m_cnt = 0;
    endtask

    task automatic model_accept(input logic [W-1:0] g, input bit clr);
        logic [W-1:0] b;
        int d;
        b = g2b(g);
        e_up = 0; e_dn = 0; e_err = 0;
        if (!m_valid) begin
            m_valid = 1;
            m_bin   = b;
        end else if (b != m_bin) begin
            d = (int'(b) - int'(m_bin)) & ((1 << W) - 1);
            if (d == 1) begin
                e_up = 1; m_pos = m_pos + 1'b1;
            end else if (d == (1 << W) - 1) begin
                e_dn = 1; m_pos = m_pos - 1'b1;
            end else begin
                e_err = 1; m_flag = 1;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
            m_bin = b;
        end
        if (clr) begin
            m_pos = '0; m_flag = 0; m_cnt = 0;
        end
    endtask

    task automatic hold(input logic [W-1:0] g, input int n);
        gray_in = g;
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_accept(input logic [W-1:0] g);
        hold(g, 8);
        model_accept(g, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        int b_up, b_dn, b_err;
        rst_n = 1'b0; gray_in = '0; clear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({valid, bin_out, step_up, step_dn, err, err_flag, err_count, pos} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b bin=%0d pos=%0d errcnt=%0d exp all zero",
                     valid, bin_out, pos, err_count);
        end
        b_up = n_up; b_dn = n_dn; b_err = n_err;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        model_accept(4'b0000, 1'b0);
        total++;
        if (valid !== 1'b1 || bin_out !== m_bin || pos !== m_pos) begin
            bad++;
            $display("FAIL reset_baseline got valid=%b bin=%0d pos=%0d exp valid=1 bin=%0d pos=%0d",
                     valid, bin_out, pos, m_bin, m_pos);
        end
        repeat (5) @(negedge clk);
        total++;
        if (n_up != b_up || n_dn != b_dn || n_err != b_err) begin
            bad++;
            $display("FAIL reset_no_pulse got up=%0d dn=%0d err=%0d exp 0",
                     n_up - b_up, n_dn - b_dn, n_err - b_err);
        end
    endtask

    task automatic test_up_sweep();
        int b_up = n_up;
        logic [W-1:0] codes [4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
        foreach (codes[i]) begin
            hold(codes[i], 10);
            model_accept(codes[i], 1'b0);
        end
        total++;
        if (n_up - b_up != 4) begin
            bad++; $display("FAIL sweep_steps got=%0d exp=4", n_up - b_up);
        end
        total++;
        if (bin_out !== m_bin || pos !== m_pos || err_flag !== m_flag) begin
            bad++;
            $display("FAIL sweep_state got bin=%0d pos=%0d flag=%b exp bin=%0d pos=%0d flag=%b",
                     bin_out, pos, err_flag, m_bin, m_pos, m_flag);
        end
    endtask

    task automatic test_down_wrap();
        int b_dn;
        pulse_reset();
        hold_accept(4'b0000);
        b_dn = n_dn;
        hold_accept(4'b1000);
        total++;
        if (n_dn - b_dn != 1 || bin_out !== 4'd15 || pos !== 16'hFFFF || m_pos !== 16'hFFFF) begin
            bad++;
            $display("FAIL down_wrap got dn=%0d bin=%0d pos=%h exp dn=1 bin=15 pos=ffff",
                     n_dn - b_dn, bin_out, pos);
        end
    endtask

    task automatic test_glitch();
        int b_up, b_dn, b_err;
        hold_accept(4'b0001);
        b_up = n_up; b_dn = n_dn; b_err = n_err;
        hold(4'b0011, 2);
        hold(4'b0001, 10);
        total++;
        if (n_up != b_up || n_dn != b_dn || n_err != b_err || bin_out !== 4'd1) begin
            bad++;
            $display("FAIL glitch_reject got up=%0d dn=%0d err=%0d bin=%0d exp 0 0 0 bin=1",
                     n_up - b_up, n_dn - b_dn, n_err - b_err, bin_out);
        end
        hold_accept(4'b0011);
        total++;
        if (n_up - b_up != 1 || bin_out !== 4'd2 || pos !== m_pos) begin
            bad++;
            $display("FAIL glitch_accept got up=%0d bin=%0d pos=%0d exp up=1 bin=2 pos=%0d",
                     n_up - b_up, bin_out, pos, m_pos);
        end
    endtask

    task automatic test_illegal();
        int b_up, b_err;
        hold_accept(4'b0000);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_accept(4'b0000, 1'b1);
        b_up = n_up; b_err = n_err;
        hold_accept(4'b0010);
        total++;
        if (n_err - b_err != 1 || err_flag !== 1'b1 || err_count !== 8'd1 ||
            pos !== 16'd0 || bin_out !== 4'd3) begin
            bad++;
            $display("FAIL illegal_jump got err=%0d flag=%b cnt=%0d pos=%0d bin=%0d exp 1 1 1 0 3",
                     n_err - b_err, err_flag, err_count, pos, bin_out);
        end
        hold_accept(4'b0110);
        total++;
        if (n_up - b_up != 1 || pos !== 16'd1 || pos !== m_pos) begin
            bad++;
            $display("FAIL illegal_recover got up=%0d pos=%0d exp up=1 pos=1", n_up - b_up, pos);
        end
    endtask

    task automatic test_clear_step();
        int b_up;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_accept(b2g(m_bin), 1'b1);
        repeat (7) hold_accept(b2g(m_bin + 1'b1));
        total++;
        if (pos !== 16'd7) begin
            bad++; $display("FAIL clear_setup got pos=%0d exp=7", pos);
        end
        b_up = n_up;
        gray_in = b2g(m_bin + 1'b1);
        repeat (5) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_accept(gray_in, 1'b1);
        total++;
        if (step_up !== 1'b1 || pos !== m_pos) begin
            bad++;
            $display("FAIL clear_step got step_up=%b pos=%0d exp step_up=1 pos=%0d", step_up, pos, m_pos);
        end
        repeat (4) @(negedge clk);
        total++;
        if (n_up - b_up != 1 || pos !== 16'd0) begin
            bad++; $display("FAIL clear_step_after got up=%0d pos=%0d exp up=1 pos=0", n_up - b_up, pos);
        end
    endtask

    task automatic test_clear_err();
        hold_accept(b2g(m_bin + 4'd5));
        gray_in = b2g(m_bin + 4'd6);
        repeat (5) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_accept(b2g(m_bin + 4'd6), 1'b1);
        total++;
        if (err !== 1'b1 || err_flag !== 1'b0 || err_count !== 8'd0 || bin_out !== m_bin) begin
            bad++;
            $display("FAIL clear_err got err=%b flag=%b cnt=%0d bin=%0d exp err=1 flag=0 cnt=0 bin=%0d",
                     err, err_flag, err_count, bin_out, m_bin);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int b_up, b_dn, b_err;
        gray_in = b2g(m_bin + 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({valid, bin_out, step_up, step_dn, err, err_flag, err_count, pos} !== '0) begin
            bad++;
            $display("FAIL async_reset got valid=%b bin=%0d pos=%0d exp all zero", valid, bin_out, pos);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        b_up = n_up; b_dn = n_dn; b_err = n_err;
        hold_accept(4'b0101);
        total++;
        if (valid !== 1'b1 || bin_out !== m_bin || pos !== 16'd0 ||
            n_up != b_up || n_dn != b_dn || n_err != b_err) begin
            bad++;
            $display("FAIL rebaseline got valid=%b bin=%0d pos=%0d pulses=%0d exp valid=1 bin=%0d pos=0 pulses=0",
                     valid, bin_out, pos, (n_up - b_up) + (n_dn - b_dn) + (n_err - b_err), m_bin);
        end
    endtask

    task automatic test_random();
        int b_up, b_dn, b_err, r;
        logic [W-1:0] g;
        for (int it = 0; it < 60; it++) begin
            b_up = n_up; b_dn = n_dn; b_err = n_err;
            if ($urandom_range(0, 1) == 1) hold(W'($urandom), $urandom_range(1, S - 1));
            r = $urandom_range(0, 3);
            case (r)
                0:       g = b2g(m_bin + 1'b1);
                1:       g = b2g(m_bin - 1'b1);
                2:       g = b2g(m_bin);
                default: g = W'($urandom);
            endcase
            hold_accept(g);
            total++;
            if (bin_out !== m_bin || pos !== m_pos || err_flag !== m_flag ||
                err_count !== 8'(m_cnt) || n_up - b_up != e_up ||
                n_dn - b_dn != e_dn || n_err - b_err != e_err) begin
                bad++;
                $display("FAIL random[%0d] got bin=%0d pos=%0d flag=%b cnt=%0d up=%0d dn=%0d err=%0d exp bin=%0d pos=%0d flag=%b cnt=%0d up=%0d dn=%0d err=%0d",
                         it, bin_out, pos, err_flag, err_count, n_up - b_up, n_dn - b_dn, n_err - b_err,
                         m_bin, m_pos, m_flag, m_cnt, e_up, e_dn, e_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_sweep();
        test_down_wrap();
        test_glitch();
        test_illegal();
        test_clear_step();
        test_clear_err();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
